// File: rtl/assign_emit_pkg.sv
// Shared encodings, ASCII constants and FSM types for the Verilog assign-statement emitter.
package assign_emit_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_BUF = 3'd4;

  localparam logic [7:0] CH_A    = 8'h61;
  localparam logic [7:0] CH_S    = 8'h73;
  localparam logic [7:0] CH_I    = 8'h69;
  localparam logic [7:0] CH_G    = 8'h67;
  localparam logic [7:0] CH_N    = 8'h6E;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_AMP  = 8'h26;
  localparam logic [7:0] CH_BAR  = 8'h7C;
  localparam logic [7:0] CH_CRT  = 8'h5E;
  localparam logic [7:0] CH_TLD  = 8'h7E;
  localparam logic [7:0] CH_SEMI = 8'h3B;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_0    = 8'h30;

  // Digit counts never exceed 5 (ID_W <= 16); index covers the 7-byte keyword.
  localparam int CNT_W = 3;
  localparam int IDX_W = 3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_KW, ST_DST, ST_EQ, ST_PRE, ST_SRCA, ST_OPSYM, ST_SRCB, ST_TAIL
  } state_t;

  typedef struct packed {
    state_t             st;
    logic [IDX_W-1:0]   idx;
  } pos_t;

  function automatic int max_digits(input int id_w);
    longint v;
    int     n;
    v = (longint'(1) << id_w) - 1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 10) begin
        v = v / 10;
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/assign_stmt_emitter_bin2dec_digits.sv
// Combinational double-dabble: binary identifier to BCD digits plus a
// leading-zero-suppressed digit count (a zero value still counts one digit).
module bin2dec_digits
  import assign_emit_pkg::*;
#(
  parameter int ID_W = 8,
  parameter int DW   = 3
) (
  input  logic [ID_W-1:0]     bin,
  output logic [DW-1:0][3:0]  bcd,
  output logic [CNT_W-1:0]    cnt
);

  logic [DW*4-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = ID_W - 1; i >= 0; i--) begin
      for (int j = 0; j < DW; j++) begin
        if (acc[j*4 +: 4] >= 4'd5) acc[j*4 +: 4] = acc[j*4 +: 4] + 4'd3;
      end
      acc = {acc[DW*4-2:0], bin[i]};
    end
  end

  always_comb begin
    cnt = CNT_W'(1);
    for (int j = 0; j < DW; j++) begin
      bcd[j] = acc[j*4 +: 4];
      if (j > 0 && acc[j*4 +: 4] != 4'd0) cnt = CNT_W'(j + 1);
    end
  end

endmodule

// File: rtl/assign_stmt_emitter.sv
// Serializes one gate record per handshake into an ASCII line
// "assign n<d> = <expr>;\n", one byte per cycle with ready/valid backpressure.
module assign_stmt_emitter
  import assign_emit_pkg::*;
#(
  parameter int ID_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [ID_W-1:0] in_dst,
  input  logic [ID_W-1:0] in_a,
  input  logic [ID_W-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic            out_last,
  output logic            err_op
);

  localparam int DW = max_digits(ID_W);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [2:0]           op_p1;
  logic                 accept;
  pos_t                 cur, adv;
  logic [7:0]           adv_char;

  logic [DW-1:0][3:0]   dst_dig_p0, a_dig_p0, b_dig_p0;
  logic [CNT_W-1:0]     dst_cnt_p0, a_cnt_p0, b_cnt_p0;
  logic [DW-1:0][3:0]   dst_dig_p1, a_dig_p1, b_dig_p1;
  logic [CNT_W-1:0]     dst_cnt_p1, a_cnt_p1, b_cnt_p1;

  assign accept = in_valid && in_ready;

  bin2dec_digits #(.ID_W(ID_W), .DW(DW)) u_dst (.bin(in_dst), .bcd(dst_dig_p0), .cnt(dst_cnt_p0));
  bin2dec_digits #(.ID_W(ID_W), .DW(DW)) u_a   (.bin(in_a),   .bcd(a_dig_p0),   .cnt(a_cnt_p0));
  bin2dec_digits #(.ID_W(ID_W), .DW(DW)) u_b   (.bin(in_b),   .bcd(b_dig_p0),   .cnt(b_cnt_p0));

  // p0 -> p1: digit arrays registered at acceptance, stable for the whole statement
  always_ff @(posedge clk) begin
    if (accept) begin
      dst_dig_p1 <= dst_dig_p0;
      a_dig_p1   <= a_dig_p0;
      b_dig_p1   <= b_dig_p0;
      dst_cnt_p1 <= dst_cnt_p0;
      a_cnt_p1   <= a_cnt_p0;
      b_cnt_p1   <= b_cnt_p0;
    end
  end

  function automatic logic [7:0] dig_char(input logic [DW-1:0][3:0] d,
                                          input logic [CNT_W-1:0] cnt,
                                          input logic [IDX_W-1:0] i);
    logic [CNT_W-1:0] k;
    logic [7:0]       r;
    k = cnt - CNT_W'(i);
    r = CH_0;
    for (int j = 0; j < DW; j++) begin
      if (CNT_W'(j) == k) r = CH_0 + {4'd0, d[j]};
    end
    return r;
  endfunction

  function automatic logic is_binary(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
  endfunction

  // Position that follows the byte currently presented.
  always_comb begin
    cur = '{st: state, idx: idx};
    adv = '{st: state, idx: idx + IDX_W'(1)};
    case (state)
      ST_KW:    if (idx == IDX_W'(6)) adv = '{st: ST_DST, idx: '0};
      ST_DST:   if (idx == IDX_W'(dst_cnt_p1)) adv = '{st: ST_EQ, idx: '0};
      ST_EQ:    if (idx == IDX_W'(2))
                  adv = '{st: (op_p1 == OP_NOT) ? ST_PRE : ST_SRCA, idx: '0};
      ST_PRE:   adv = '{st: ST_SRCA, idx: '0};
      ST_SRCA:  if (idx == IDX_W'(a_cnt_p1))
                  adv = '{st: is_binary(op_p1) ? ST_OPSYM : ST_TAIL, idx: '0};
      ST_OPSYM: if (idx == IDX_W'(2)) adv = '{st: ST_SRCB, idx: '0};
      ST_SRCB:  if (idx == IDX_W'(b_cnt_p1)) adv = '{st: ST_TAIL, idx: '0};
      ST_TAIL:  if (idx == IDX_W'(1)) adv = '{st: ST_IDLE, idx: '0};
      default:  adv = cur;
    endcase
  end

  always_comb begin
    adv_char = CH_SP;
    case (adv.st)
      ST_KW: begin
        case (adv.idx)
          3'd0:    adv_char = CH_A;
          3'd1:    adv_char = CH_S;
          3'd2:    adv_char = CH_S;
          3'd3:    adv_char = CH_I;
          3'd4:    adv_char = CH_G;
          3'd5:    adv_char = CH_N;
          default: adv_char = CH_SP;
        endcase
      end
      ST_DST:   adv_char = (adv.idx == '0) ? CH_N : dig_char(dst_dig_p1, dst_cnt_p1, adv.idx);
      ST_EQ:    adv_char = (adv.idx == IDX_W'(1)) ? CH_EQ : CH_SP;
      ST_PRE:   adv_char = CH_TLD;
      ST_SRCA:  adv_char = (adv.idx == '0) ? CH_N : dig_char(a_dig_p1, a_cnt_p1, adv.idx);
      ST_OPSYM: begin
        if (adv.idx == IDX_W'(1))
          adv_char = (op_p1 == OP_AND) ? CH_AMP : (op_p1 == OP_OR) ? CH_BAR : CH_CRT;
        else
          adv_char = CH_SP;
      end
      ST_SRCB:  adv_char = (adv.idx == '0) ? CH_N : dig_char(b_dig_p1, b_cnt_p1, adv.idx);
      ST_TAIL:  adv_char = (adv.idx == '0) ? CH_SEMI : CH_LF;
      default:  adv_char = CH_SP;
    endcase
  end

  // p1 -> output: state and the presented byte advance only on a sink handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      op_p1     <= OP_AND;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      err_op    <= 1'b0;
    end else begin
      err_op <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          op_p1 <= in_op;
          if (in_op <= OP_BUF) begin
            state     <= ST_KW;
            idx       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= CH_A;
            out_last  <= 1'b0;
          end else begin
            err_op <= 1'b1;
          end
        end
      end else if (out_valid && out_ready) begin
        state <= adv.st;
        idx   <= adv.idx;
        if (adv.st == ST_IDLE) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          in_ready  <= 1'b1;
        end else begin
          out_data <= adv_char;
          out_last <= (adv.st == ST_TAIL) && (adv.idx == IDX_W'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_assign_stmt_emitter.sv
// Directed bench for assign_stmt_emitter: expected lines are written out by hand.
module tb_assign_stmt_emitter;

  logic       clk, rst;
  logic       in_valid, in_ready;
  logic [2:0] in_op;
  logic [7:0] in_dst, in_a, in_b;
  logic       out_valid, out_ready, out_last, err_op;
  logic [7:0] out_data;

  int tests_run = 0;
  int tests_failed = 0;

  assign_stmt_emitter #(.ID_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_dst(in_dst), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .err_op(err_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] d, input logic [7:0] a,
                      input logic [7:0] b);
    in_op = op; in_dst = d; in_a = a; in_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called one cycle after acceptance; receives the whole line, optionally stalling.
  task automatic collect(input string tag, input string exp, input bit rnd);
    int         n = 0;
    int         cyc = 0;
    bit         stalled = 0;
    logic [7:0] hold_data = 8'h00;
    logic       hold_last = 1'b0;
    check_eq({tag, "/first_lat"}, out_valid, 1);
    while (n < exp.len() && cyc < 400) begin
      if (stalled)
        check_eq($sformatf("%s/hold%0d", tag, n), {out_valid, out_last, out_data},
                 {1'b1, hold_last, hold_data});
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) check_eq({tag, "/busy_ready"}, in_ready, 0);
      if (out_valid && out_ready) begin
        check_eq($sformatf("%s/byte%0d", tag, n), out_data, exp[n]);
        check_eq($sformatf("%s/last%0d", tag, n), out_last, (n == exp.len() - 1));
        n++;
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1;
        hold_data = out_data;
        hold_last = out_last;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    check_eq({tag, "/len"}, n, exp.len());
    check_eq({tag, "/done_valid"}, out_valid, 0);
    check_eq({tag, "/done_ready"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 3'd0; in_dst = 8'd0; in_a = 8'd0; in_b = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_err_op", err_op, 0);
    @(posedge clk); #1;

    send(3'd0, 8'd5, 8'd1, 8'd2);
    collect("and", "assign n5 = n1 & n2;\n", 0);

    send(3'd3, 8'd255, 8'd0, 8'd77);
    collect("not", "assign n255 = ~n0;\n", 0);

    send(3'd4, 8'd10, 8'd100, 8'd3);
    collect("buf", "assign n10 = n100;\n", 0);

    send(3'd1, 8'd200, 8'd13, 8'd0);
    collect("or", "assign n200 = n13 | n0;\n", 0);

    send(3'd2, 8'd7, 8'd8, 8'd9);
    collect("xor_bp", "assign n7 = n8 ^ n9;\n", 1);

    // Illegal op: consumed, single err_op pulse, no bytes
    send(3'd6, 8'd1, 8'd2, 8'd3);
    check_eq("ill_err", err_op, 1);
    check_eq("ill_ready", in_ready, 1);
    check_eq("ill_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("ill_err_low", err_op, 0);
      check_eq("ill_no_valid", out_valid, 0);
    end

    // in_valid held high with other fields during emission is ignored until after LF
    send(3'd0, 8'd3, 8'd4, 8'd5);
    in_valid = 1'b1; in_op = 3'd4; in_dst = 8'd99; in_a = 8'd98; in_b = 8'd97;
    collect("inflight", "assign n3 = n4 & n5;\n", 0);
    send(3'd4, 8'd99, 8'd98, 8'd97);
    collect("after", "assign n99 = n98;\n", 0);

    // Reset while the 10th byte of an OR line is presented
    send(3'd1, 8'd12, 8'd34, 8'd56);
    repeat (9) @(posedge clk);
    #1;
    check_eq("mid_byte10", out_data, 8'h32);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_data", out_data, 0);
    check_eq("mid_rst_last", out_last, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("mid_rel_ready", in_ready, 1);
    check_eq("mid_rel_valid", out_valid, 0);
    send(3'd1, 8'd12, 8'd34, 8'd56);
    collect("fresh", "assign n12 = n34 | n56;\n", 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
